decoder_select_arbiter: RTL and testbench

- Round-robin arbiter sharing one 16-way decoded resource, such as a register-file write port, among 16 requesters.
- Produces a registered 4-bit select that drives the 4-to-16 decoder, plus a matching one-hot grant vector.
- Sequences ownership: one owner at a time, held until the owner finishes, drops its request or times out.
- Sits between the control unit's requesters and the decoder select inputs.

---
 rtl/decoder_select_arbiter.sv | 84 ++++++++
 tb/tb_decoder_select_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/decoder_select_arbiter.sv
// Round-robin arbiter that owns the select lines of a 16-way decoded resource.
// Registered select/grant, one dead cycle between owners, optional hold timeout.
module decoder_select_arbiter #(
   parameter int MAX_HOLD = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] request,
   input  logic        done,
   output logic        grant_valid,
   output logic [3:0]  grant_index,
   output logic [15:0] grant,
   output logic        timeout_pulse
);

   typedef enum logic {IDLE, GRANTED} state_t;

   localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

   state_t     state;
   logic [3:0] pointer;
   logic [7:0] hold_count;
   logic [3:0] winner;
   logic       winner_found;
   logic       timeout_hit;
   logic       release_now;

   // Search begins at the pointer, so the previous winner is examined last.
   always_comb begin
      winner       = 4'd0;
      winner_found = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (!winner_found && request[pointer + 4'(i)]) begin
            winner       = pointer + 4'(i);
            winner_found = 1'b1;
         end
      end
   end

   always_comb begin
      timeout_hit = (MAX_HOLD != 0) && (hold_count == HOLD_LAST);
      release_now = done || !request[grant_index] || timeout_hit;
   end

   // Every release returns to IDLE, which guarantees a dead cycle before the select moves.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         pointer       <= 4'd0;
         hold_count    <= 8'd0;
         grant_valid   <= 1'b0;
         grant_index   <= 4'd0;
         grant         <= 16'd0;
         timeout_pulse <= 1'b0;
      end else begin
         timeout_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (winner_found) begin
                  state       <= GRANTED;
                  grant_valid <= 1'b1;
                  grant_index <= winner;
                  grant       <= 16'd1 << winner;
                  pointer     <= winner + 4'd1;
                  hold_count  <= 8'd0;
               end
            end
            GRANTED: begin
               if (release_now) begin
                  state         <= IDLE;
                  grant_valid   <= 1'b0;
                  grant         <= 16'd0;
                  hold_count    <= 8'd0;
                  timeout_pulse <= timeout_hit && !done && request[grant_index];
               end else if (hold_count != 8'hFF) begin
                  hold_count <= hold_count + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_decoder_select_arbiter.sv
// Bench for decoder_select_arbiter: directed scenarios plus random traffic,
// every cycle compared against a behavioural ownership model.
module tb_decoder_select_arbiter;

   localparam int MAXH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] request;
   logic        done;
   logic        grant_valid;
   logic [3:0]  grant_index;
   logic [15:0] grant;
   logic        timeout_pulse;

   int tests    = 0;
   int failures = 0;

   int mOwner;
   int mPtr;
   int mHold;
   int mIdx;
   bit mTo;

   decoder_select_arbiter #(.MAX_HOLD(MAXH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .request       (request),
      .done          (done),
      .grant_valid   (grant_valid),
      .grant_index   (grant_index),
      .grant         (grant),
      .timeout_pulse (timeout_pulse)
   );

   always #5 clk = ~clk;

   // Owner is -1 when nobody holds the resource.
   task automatic modelEdge();
      bit a, b, c, found;
      int cand;
      if (!rst_n) begin
         mOwner = -1; mPtr = 0; mHold = 0; mIdx = 0; mTo = 0;
      end else if (mOwner < 0) begin
         mTo   = 0;
         found = 0;
         for (int k = 0; k < 16; k++) begin
            cand = (mPtr + k) % 16;
            if (!found && request[cand]) begin
               found  = 1;
               mOwner = cand;
            end
         end
         if (found) begin
            mIdx  = mOwner;
            mPtr  = (mOwner + 1) % 16;
            mHold = 0;
         end
      end else begin
         a = done;
         b = !request[mOwner];
         c = (MAXH != 0) && (mHold == MAXH - 1);
         if (a || b || c) begin
            mTo    = c && !a && !b;
            mOwner = -1;
            mHold  = 0;
         end else begin
            mTo = 0;
            if (mHold < 255) mHold++;
         end
      end
   endtask

   task automatic checkValue(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      logic [15:0] expGrant;
      expGrant = (mOwner >= 0) ? (16'd1 << mOwner) : 16'd0;
      checkValue("grant_valid", {15'd0, grant_valid}, {15'd0, mOwner >= 0});
      checkValue("grant_index", {12'd0, grant_index}, 16'(mIdx));
      checkValue("grant", grant, expGrant);
      checkValue("timeout_pulse", {15'd0, timeout_pulse}, {15'd0, mTo});
   endtask

   task automatic applyStimulus(input logic r, input logic [15:0] req, input logic d);
      rst_n   = r;
      request = req;
      done    = d;
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput();
   endtask

   initial begin
      int order[6];
      logic [15:0] req;
      order = '{0, 1, 15, 0, 1, 15};
      mOwner = -1; mPtr = 0; mHold = 0; mIdx = 0; mTo = 0;

      // Reset held against full request traffic.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 16'hFFFF, 1'b0);
         checkValue("reset_grant", grant, 16'h0000);
      end
      applyStimulus(1'b1, 16'hFFFF, 1'b0);
      checkValue("first_after_reset", {12'd0, grant_index}, 16'd0);
      applyStimulus(1'b1, 16'h0000, 1'b0);

      // Single requester with completion on its third granted cycle.
      applyStimulus(1'b1, 16'h0020, 1'b0);
      checkValue("single_grant", grant, 16'h0020);
      applyStimulus(1'b1, 16'h0020, 1'b0);
      applyStimulus(1'b1, 16'h0020, 1'b0);
      checkValue("single_idx", {12'd0, grant_index}, 16'd5);
      applyStimulus(1'b1, 16'h0020, 1'b1);
      checkValue("single_dead", {15'd0, grant_valid}, 16'd0);
      applyStimulus(1'b1, 16'h0020, 1'b0);
      checkValue("single_regrant", grant, 16'h0020);

      // Round-robin wrap from 15 back to 0.
      applyStimulus(1'b0, 16'h0000, 1'b0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 16'h8003, 1'b0);
         checkValue("rr_order", {12'd0, grant_index}, 16'(order[i]));
         applyStimulus(1'b1, 16'h8003, 1'b1);
      end

      // Timeout after four held cycles, then completion on the fourth cycle.
      applyStimulus(1'b1, 16'h0100, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'h0100, 1'b0);
      checkValue("to_held", {15'd0, grant_valid}, 16'd1);
      applyStimulus(1'b1, 16'h0100, 1'b0);
      checkValue("to_pulse", {15'd0, timeout_pulse}, 16'd1);
      applyStimulus(1'b1, 16'h0100, 1'b0);
      checkValue("to_regrant", grant, 16'h0100);
      for (int i = 0; i < 2; i++) applyStimulus(1'b1, 16'h0100, 1'b0);
      applyStimulus(1'b1, 16'h0100, 1'b0);
      applyStimulus(1'b1, 16'h0100, 1'b1);
      checkValue("done_no_pulse", {15'd0, timeout_pulse}, 16'd0);

      // Owner 3 drops its request while 7 waits.
      applyStimulus(1'b0, 16'h0000, 1'b0);
      applyStimulus(1'b1, 16'h0008, 1'b0);
      applyStimulus(1'b1, 16'h0088, 1'b0);
      applyStimulus(1'b1, 16'h0080, 1'b0);
      checkValue("drop_no_pulse", {15'd0, timeout_pulse}, 16'd0);
      applyStimulus(1'b1, 16'h0080, 1'b0);
      checkValue("drop_next", {12'd0, grant_index}, 16'd7);
      applyStimulus(1'b1, 16'h0080, 1'b1);

      // Reset while owner 12 holds, pointer must clear.
      applyStimulus(1'b0, 16'h0000, 1'b0);
      applyStimulus(1'b1, 16'h1000, 1'b0);
      checkValue("mid_owner", {12'd0, grant_index}, 16'd12);
      applyStimulus(1'b0, 16'h1000, 1'b0);
      checkValue("mid_reset", grant, 16'h0000);
      applyStimulus(1'b1, 16'h1001, 1'b0);
      checkValue("mid_after", {12'd0, grant_index}, 16'd0);

      // Random traffic; repeated patterns give owners time to reach the timeout.
      req = 16'h0000;
      for (int i = 0; i < 800; i++) begin
         case ($urandom_range(0, 3))
            0: req = 16'h0000;
            1: req = 16'd1 << $urandom_range(0, 15);
            2: req = 16'($urandom);
            default: req = req;
         endcase
         applyStimulus(($urandom_range(0, 49) != 0), req, ($urandom_range(0, 5) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
